// File: rtl/pixel_stream_splitter.sv
// pixel_stream_splitter: steers BLOCK_LEN-pixel blocks alternately to two
//   destinations through a one-entry hold register with valid/ready handshakes.
// Ports: clk, rst (async, active high), clr (sync restart);
//   s_data/s_valid/s_ready : input pixel stream
//   sel, m_data            : demux select and held pixel
//   m1_valid/m1_ready, m2_valid/m2_ready : per-destination handshakes
//   blk_done, blk_cnt      : block-end pulse and in-block pixel count
module pixel_stream_splitter #(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 28,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sel,
  output logic [DATA_W-1:0] m_data,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic              m2_valid,
  input  logic              m2_ready,
  output logic              blk_done,
  output logic [CNT_W-1:0]  blk_cnt
);

  typedef enum logic {DEST1 = 1'b0, DEST2 = 1'b1} route_e;

  // One bit wider than the counter so BLOCK_LEN = 2^CNT_W fits.
  localparam logic [CNT_W:0] LEN = (CNT_W+1)'(BLOCK_LEN);

  route_e            route_q, route_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              hdst_q, hdst_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              in_fire;
  logic              out_fire;
  logic [CNT_W:0]    cnt_inc;
  logic              wrap;

  always_comb begin
    m1_valid = full_q & ~hdst_q;
    m2_valid = full_q & hdst_q;
    out_fire = (m1_valid & m1_ready) | (m2_valid & m2_ready);
    s_ready  = ~full_q | out_fire;
    in_fire  = s_valid & s_ready;
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    wrap     = in_fire & (cnt_inc == LEN);
  end

  // Routing FSM and block counter.
  always_comb begin
    route_d = route_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (in_fire) begin
      if (wrap) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        unique case (route_q)
          DEST1:   route_d = DEST2;
          DEST2:   route_d = DEST1;
          default: route_d = DEST1;
        endcase
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
    if (clr) begin
      cnt_d   = '0;
      route_d = DEST1;
      done_d  = 1'b0;
    end
  end

  // Hold register: the accepted pixel keeps the pre-toggle route.
  always_comb begin
    full_d = full_q;
    hdst_d = hdst_q;
    data_d = data_q;
    if (in_fire) begin
      full_d = 1'b1;
      hdst_d = route_q;
      data_d = s_data;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_q <= DEST1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      hdst_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      route_q <= route_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      full_q  <= full_d;
      hdst_q  <= hdst_d;
      data_q  <= data_d;
    end
  end

  assign sel      = full_q ? hdst_q : route_q;
  assign m_data   = data_q;
  assign blk_done = done_q;
  assign blk_cnt  = cnt_q;

endmodule

// File: tb/tb_pixel_stream_splitter.sv
// tb_pixel_stream_splitter: directed vectors on BLOCK_LEN 4 and 1 instances,
//   plus a randomized scoreboard run on a BLOCK_LEN 28 instance.
module tb_pixel_stream_splitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       m1_ready = 1'b0;
  logic       m2_ready = 1'b0;

  logic       s_ready4, sel4, m1v4, m2v4, done4;
  logic [7:0] m_data4;
  logic [4:0] cnt4;
  logic       s_ready1, sel1, m1v1, m2v1, done1;
  logic [7:0] m_data1;
  logic [4:0] cnt1;
  logic       s_ready28, sel28, m1v28, m2v28, done28;
  logic [7:0] m_data28;
  logic [4:0] cnt28;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_stream_splitter #(.DATA_W(8), .BLOCK_LEN(4), .CNT_W(5)) u4 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready4),
    .sel(sel4), .m_data(m_data4),
    .m1_valid(m1v4), .m1_ready(m1_ready),
    .m2_valid(m2v4), .m2_ready(m2_ready),
    .blk_done(done4), .blk_cnt(cnt4)
  );

  pixel_stream_splitter #(.DATA_W(8), .BLOCK_LEN(1), .CNT_W(5)) u1 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .sel(sel1), .m_data(m_data1),
    .m1_valid(m1v1), .m1_ready(m1_ready),
    .m2_valid(m2v1), .m2_ready(m2_ready),
    .blk_done(done1), .blk_cnt(cnt1)
  );

  pixel_stream_splitter #(.DATA_W(8), .BLOCK_LEN(28), .CNT_W(5)) u28 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready28),
    .sel(sel28), .m_data(m_data28),
    .m1_valid(m1v28), .m1_ready(m1_ready),
    .m2_valid(m2v28), .m2_ready(m2_ready),
    .blk_done(done28), .blk_cnt(cnt28)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid  = 1'b0;
    clr      = 1'b0;
    rst      = 1'b0;
    #1;
    rst      = 1'b1;
    m1_ready = 1'b0;
    m2_ready = 1'b0;
    #1;
    chk("rst m1_valid", 32'(m1v4), 0);
    chk("rst m2_valid", 32'(m2v4), 0);
    chk("rst m_data", 32'(m_data4), 0);
    chk("rst sel", 32'(sel4), 0);
    chk("rst blk_cnt", 32'(cnt4), 0);
    chk("rst blk_done", 32'(done4), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst s_ready", 32'(s_ready4), 1);
  endtask

  int q1[$];
  int q2[$];
  int sent, nacc, ndone, cyc;
  logic f_in, f1, f2;
  int e;

  initial begin
    // Back-to-back stream, block of 4
    do_reset();
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_data  = 8'(k);
      s_valid = 1'b1;
      tick();
      chk("t1 m_data", 32'(m_data4), 32'(k));
      chk("t1 m1_valid", 32'(m1v4), 32'(k <= 4));
      chk("t1 m2_valid", 32'(m2v4), 32'(k > 4));
      chk("t1 sel", 32'(sel4), 32'(k > 4));
      chk("t1 blk_done", 32'(done4), 32'(k % 4 == 0));
      chk("t1 blk_cnt", 32'(cnt4), 32'(k % 4));
    end
    s_valid = 1'b0;
    tick();
    chk("t1 drain m1", 32'(m1v4), 0);
    chk("t1 drain m2", 32'(m2v4), 0);
    chk("t1 idle sel", 32'(sel4), 0);

    // Back-pressure on destination 1
    do_reset();
    m2_ready = 1'b1;
    s_data   = 8'h01;
    s_valid  = 1'b1;
    tick();
    s_data = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2 stall s_ready", 32'(s_ready4), 0);
      chk("t2 stall m_data", 32'(m_data4), 32'h01);
      chk("t2 stall m1_valid", 32'(m1v4), 1);
      chk("t2 stall m2_valid", 32'(m2v4), 0);
      tick();
    end
    m1_ready = 1'b1;
    #1;
    chk("t2 release s_ready", 32'(s_ready4), 1);
    tick();
    chk("t2 m_data", 32'(m_data4), 32'h02);
    for (int k = 3; k <= 5; k++) begin
      s_data = 8'(k);
      tick();
      chk("t2 m_data", 32'(m_data4), 32'(k));
      chk("t2 m1_valid", 32'(m1v4), 32'(k <= 4));
      chk("t2 m2_valid", 32'(m2v4), 32'(k > 4));
    end
    s_valid = 1'b0;
    tick();

    // clr in the middle of a DEST2 block
    do_reset();
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    s_valid  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      s_data = 8'(k);
      tick();
    end
    m2_ready = 1'b0;
    s_valid  = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3 held m2_valid", 32'(m2v4), 1);
    chk("t3 held m_data", 32'(m_data4), 32'h06);
    chk("t3 clr blk_cnt", 32'(cnt4), 0);
    chk("t3 held sel", 32'(sel4), 1);
    m2_ready = 1'b1;
    s_data   = 8'h07;
    s_valid  = 1'b1;
    tick();
    chk("t3 post m_data", 32'(m_data4), 32'h07);
    chk("t3 post m1_valid", 32'(m1v4), 1);
    chk("t3 post m2_valid", 32'(m2v4), 0);
    chk("t3 post blk_cnt", 32'(cnt4), 1);
    chk("t3 post sel", 32'(sel4), 0);
    s_data = 8'h08;
    clr    = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3 clr+in m_data", 32'(m_data4), 32'h08);
    chk("t3 clr+in m1_valid", 32'(m1v4), 1);
    chk("t3 clr+in blk_cnt", 32'(cnt4), 0);
    chk("t3 clr+in blk_done", 32'(done4), 0);
    s_valid = 1'b0;
    tick();

    // Async reset with a pixel held for destination 2
    do_reset();
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    s_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      s_data = 8'(k);
      tick();
    end
    m2_ready = 1'b0;
    s_valid  = 1'b0;
    tick();
    chk("t4 held m2_valid", 32'(m2v4), 1);
    chk("t4 held m_data", 32'(m_data4), 32'h05);
    #2;
    do_reset();
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    s_data   = 8'h33;
    s_valid  = 1'b1;
    tick();
    chk("t4 after m1_valid", 32'(m1v4), 1);
    chk("t4 after m2_valid", 32'(m2v4), 0);
    chk("t4 after m_data", 32'(m_data4), 32'h33);
    s_valid = 1'b0;
    tick();

    // BLOCK_LEN of 1
    do_reset();
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    s_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 8'hA0 + 8'(k);
      tick();
      chk("t5 m_data", 32'(m_data1), 32'hA0 + 32'(k));
      chk("t5 m1_valid", 32'(m1v1), 32'(k != 1));
      chk("t5 m2_valid", 32'(m2v1), 32'(k == 1));
      chk("t5 blk_done", 32'(done1), 1);
    end
    s_valid = 1'b0;
    tick();
    chk("t5 done low", 32'(done1), 0);

    // Random traffic, BLOCK_LEN of 28
    do_reset();
    sent  = 0;
    nacc  = 0;
    ndone = 0;
    cyc   = 0;
    while ((sent < 1000 || q1.size() != 0 || q2.size() != 0)
           && cyc < 20000) begin
      s_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      s_data   = 8'(sent);
      m1_ready = ($urandom_range(0, 1) == 1);
      m2_ready = ($urandom_range(0, 1) == 1);
      #1;
      f_in = s_valid & s_ready28;
      f1   = m1v28 & m1_ready;
      f2   = m2v28 & m2_ready;
      if (m1v28 && m2v28) chk("t6 both valid", 1, 0);
      if (f1) begin
        e = (q1.size() != 0) ? q1.pop_front() : -1;
        chk("t6 m1 data", 32'(m_data28), 32'(e));
      end
      if (f2) begin
        e = (q2.size() != 0) ? q2.pop_front() : -1;
        chk("t6 m2 data", 32'(m_data28), 32'(e));
      end
      if (f_in) begin
        if (((nacc / 28) % 2) == 0) q1.push_back(nacc & 255);
        else q2.push_back(nacc & 255);
        nacc++;
        sent++;
      end
      tick();
      if (done28) ndone++;
      cyc++;
    end
    chk("t6 timeout", 32'(cyc < 20000), 1);
    chk("t6 accepted", 32'(nacc), 1000);
    chk("t6 blk_done count", 32'(ndone), 35);
    chk("t6 q1 empty", 32'(q1.size()), 0);
    chk("t6 q2 empty", 32'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_splitter.md
Name: pixel_stream_splitter

Overview:
- Accepts an 8-bit pixel stream over a valid/ready handshake.
- Steers consecutive blocks of BLOCK_LEN pixels alternately to two destinations, for example ping-pong row buffers feeding the two halves of a conv stage.
- Generates internally the select that drives the downstream 8-bit 1-to-2 demux, and holds each pixel in a one-entry output register so it can absorb back-pressure.
- Sits between the pixel source and that demux/consumer pair.

Parameters:
- DATA_W, 8: pixel width in bits.
- BLOCK_LEN, 28: pixels per block before the destination toggles. Legal range is 1..2^CNT_W.
- CNT_W, 5: width of the in-block pixel counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous restart. Zeroes the counter and points sel at destination 1.
- s_data  input  DATA_W  incoming pixel.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  splitter can accept the pixel this cycle.
- sel  output  1  destination of the pixel currently held or next accepted. 0 = dest 1, 1 = dest 2. Drives the demux select.
- m_data  output  DATA_W  held pixel. Goes to the demux din.
- m1_valid  output  1  held pixel is valid for destination 1.
- m1_ready  input  1  destination 1 accepts.
- m2_valid  output  1  held pixel is valid for destination 2.
- m2_ready  input  1  destination 2 accepts.
- blk_done  output  1  one-cycle pulse when the last pixel of a block is accepted on s.
- blk_cnt  output  CNT_W  number of pixels accepted so far in the current block.

Behaviour:
- Reset (asynchronous, any time, including mid-block):
  - sel=0, blk_cnt=0, m_data=0, m1_valid=0, m2_valid=0, blk_done=0.
  - s_ready=1 in the first cycle after rst deasserts.
  - A held pixel is discarded.
- Hold register:
  - One entry: full flag, data, destination bit hdst.
  - m1_valid = full & ~hdst; m2_valid = full & hdst.
  - Drain: out_fire = (m1_valid & m1_ready) | (m2_valid & m2_ready).
- Input side:
  - s_ready = ~full | out_fire. This is a combinational pass-through of the ready, so sustained throughput is 1 pixel/cycle.
  - in_fire = s_valid & s_ready. On in_fire the register loads data = s_data, hdst = route bit, full = 1.
  - If out_fire occurs without in_fire, full goes to 0.
  - Latency from in_fire to m*_valid is 1 cycle.
- Routing state machine:
  - Two states, DEST1 (route=0) and DEST2 (route=1).
  - On each in_fire, blk_cnt increments.
  - When an accepted pixel makes the count reach BLOCK_LEN:
    - blk_cnt wraps to 0;
    - route toggles (DEST1 <-> DEST2);
    - blk_done is 1 in the following cycle, for exactly one cycle.
  - The toggle applies to the next accepted pixel only. The pixel just accepted keeps its old hdst.
- sel output:
  - sel = hdst while full; otherwise sel = route.
  - sel therefore always matches the destination of the pixel on m_data.
- clr:
  - Sets blk_cnt=0 and route=DEST1 and suppresses blk_done.
  - Does not flush the hold register; a held pixel still drains to its recorded hdst.
  - clr and in_fire in the same cycle: the pixel is accepted with the pre-clr route, and the counter ends at 0.
- Simultaneous in_fire and out_fire: the register is replaced, with no bubble and no loss.
- Back-pressure:
  - While a destination's ready is low, the held pixel stays stable.
  - The inactive destination's valid stays 0.
  - The input stalls once the register is full.
- m_data and the valids are registered; no combinational path from s_data to m_data.
- BLOCK_LEN=1: route toggles on every accepted pixel, and blk_done pulses for each one.
- Counter arithmetic is unsigned CNT_W-bit. The compare against BLOCK_LEN is done in CNT_W+1 bits so that BLOCK_LEN=2^CNT_W is legal.

Test Plan:
- Reset, then BLOCK_LEN=4, both readies=1, stream 0x01..0x08 back-to-back:
  - 0x01..0x04 appear on m1 in cycles 1..4, then 0x05..0x08 on m2.
  - sel: 0,0,0,0,1,1,1,1.
  - blk_done pulses after 0x04 and after 0x08.
- BLOCK_LEN=4, m1_ready held 0 for 3 cycles while 0x01 is held:
  - s_ready=0 and m_data=0x01 are stable during the stall.
  - m2_valid=0 throughout.
  - After release, the stream resumes with no loss or duplication.
- Assert clr after 2 pixels of the second block (route=DEST2):
  - The next pixel goes to dest 1 and blk_cnt restarts at 1.
  - Any pixel already held still exits on m2.
- Assert rst mid-block with a pixel held on m2_valid:
  - All outputs go to 0 immediately (asynchronously), and the held pixel never appears.
  - After rst deasserts, the first pixel goes to dest 1.
- BLOCK_LEN=1, stream 0xA0,0xA1,0xA2:
  - Pixels go to dest 1, 2, 1 respectively.
  - blk_done pulses 3 times.
- Random s_valid and random readies at 50%, 1000 pixels, BLOCK_LEN=28:
  - Scoreboard: the per-destination ordering matches the block alternation.
  - blk_done count = floor(1000/28) = 35.
